// File: rtl/ip_hdr_csum_check.sv
// Receive-side IPv4 header checksum verifier.
// Folds the header into a one's-complement sum and reports one verdict per header.
module ip_hdr_csum_check #(
    parameter logic [3:0] MIN_IHL = 4'd5,
    parameter bit         CHK_VER = 1'b1
) (
    input  logic        CLK_i,
    input  logic        reset_i,
    input  logic [7:0]  data_i,
    input  logic        dataen_i,
    input  logic        sop_i,
    output logic        done_o,
    output logic        ok_o,
    output logic        err_hdr_o,
    output logic        err_trunc_o,
    output logic [15:0] csum_o,
    output logic [5:0]  hdr_len_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SKIP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] acc;
    logic [5:0]  cnt;
    logic [7:0]  hi;
    logic        pend_hdr;

    logic        start;
    logic        bad0;
    logic        hdr_byte;
    logic        last;
    logic [16:0] s17;
    logic [15:0] fold;

    logic        done_n;
    logic        ok_n;
    logic        err_hdr_n;
    logic        err_trunc_n;
    logic [15:0] csum_n;
    logic        pend_n;

    assign start    = dataen_i & sop_i;
    assign bad0     = (data_i[3:0] < MIN_IHL) ||
                      (CHK_VER && (data_i[7:4] != 4'd4));
    assign hdr_byte = (state == HDR) & dataen_i & ~sop_i;
    assign last     = hdr_byte & cnt[0] & (cnt == (hdr_len_o - 6'd1));
    assign s17      = {1'b0, acc} + {1'b0, hi, data_i};
    // End-around carry; s17 never exceeds 17'h1FFFE so this cannot overflow.
    assign fold     = s17[15:0] + {15'd0, s17[16]};

    always_ff @(posedge CLK_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (start) begin
            state_n = bad0 ? SKIP : HDR;
        end else if (last) begin
            state_n = SKIP;
        end
    end

    // A truncating sop with an illegal byte 0 defers its err_hdr verdict one cycle.
    always_comb begin
        done_n      = 1'b0;
        ok_n        = 1'b0;
        err_hdr_n   = 1'b0;
        err_trunc_n = 1'b0;
        csum_n      = 16'h0000;
        pend_n      = 1'b0;
        if (start && state == HDR) begin
            done_n      = 1'b1;
            err_trunc_n = 1'b1;
            pend_n      = bad0;
        end else if (pend_hdr || (start && bad0)) begin
            done_n    = 1'b1;
            err_hdr_n = 1'b1;
        end else if (last) begin
            done_n = 1'b1;
            ok_n   = (fold == 16'hFFFF);
            csum_n = ~fold;
        end
    end

    always_ff @(posedge CLK_i or posedge reset_i) begin
        if (reset_i) begin
            done_o      <= 1'b0;
            ok_o        <= 1'b0;
            err_hdr_o   <= 1'b0;
            err_trunc_o <= 1'b0;
            csum_o      <= 16'h0000;
            pend_hdr    <= 1'b0;
        end else begin
            done_o      <= done_n;
            ok_o        <= ok_n;
            err_hdr_o   <= err_hdr_n;
            err_trunc_o <= err_trunc_n;
            csum_o      <= csum_n;
            pend_hdr    <= pend_n;
        end
    end

    always_ff @(posedge CLK_i or posedge reset_i) begin
        if (reset_i) begin
            acc       <= 16'h0000;
            cnt       <= 6'd0;
            hi        <= 8'h00;
            hdr_len_o <= 6'd0;
        end else if (start) begin
            acc       <= 16'h0000;
            cnt       <= 6'd1;
            hi        <= data_i;
            hdr_len_o <= {data_i[3:0], 2'b00};
        end else if (hdr_byte) begin
            cnt <= cnt + 6'd1;
            if (cnt[0]) begin
                acc <= fold;
            end else begin
                hi <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_ip_hdr_csum_check.sv
// Directed bench for ip_hdr_csum_check.
// Hand-computed headers; verdict flags checked right after each accepting edge.
module tb_ip_hdr_csum_check;

    logic        CLK_i;
    logic        reset_i;
    logic [7:0]  data_i;
    logic        dataen_i;
    logic        sop_i;
    logic        done_o;
    logic        ok_o;
    logic        err_hdr_o;
    logic        err_trunc_o;
    logic [15:0] csum_o;
    logic [5:0]  hdr_len_o;

    int nvec = 0;
    int nmis = 0;
    int dn;

    logic [7:0] t1 [0:19] = '{
        8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
        8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7
    };
    // IHL=6, options NOP NOP NOP EOL; checksum 63CD computed by hand.
    logic [7:0] t5 [0:23] = '{
        8'h46, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h11,
        8'h63, 8'hCD, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h02,
        8'h01, 8'h01, 8'h01, 8'h00
    };
    logic [7:0] hdr [0:59];

    ip_hdr_csum_check #(.MIN_IHL(4'd5), .CHK_VER(1'b1)) dut (
        .CLK_i       (CLK_i),
        .reset_i     (reset_i),
        .data_i      (data_i),
        .dataen_i    (dataen_i),
        .sop_i       (sop_i),
        .done_o      (done_o),
        .ok_o        (ok_o),
        .err_hdr_o   (err_hdr_o),
        .err_trunc_o (err_trunc_o),
        .csum_o      (csum_o),
        .hdr_len_o   (hdr_len_o)
    );

    initial CLK_i = 1'b0;
    always #5 CLK_i = ~CLK_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] d, input logic s, input logic e);
        @(negedge CLK_i);
        data_i   = d;
        sop_i    = s;
        dataen_i = e;
        @(posedge CLK_i);
        #1;
    endtask

    task automatic load_t1();
        for (int i = 0; i < 20; i++) hdr[i] = t1[i];
    endtask

    // Sends hdr[first..last]; counts done pulses seen after each accepted byte.
    task automatic send(input int first, input int last, input logic sop0,
                        input bit gaps, output int dones);
        dones = 0;
        for (int i = first; i <= last; i++) begin
            if (gaps && i != first) begin
                int g;
                g = $urandom_range(1, 3);
                for (int k = 0; k < g; k++) begin
                    step(8'h00, 1'b0, 1'b0);
                    if (done_o) dones++;
                end
            end
            step(hdr[i], (i == first) ? sop0 : 1'b0, 1'b1);
            if (done_o) dones++;
        end
    endtask

    task automatic verdict(input string tag, input logic ok, input logic eh,
                           input logic et, input logic [15:0] cs);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd1);
        chk({tag, "_ok"}, {31'd0, ok_o}, {31'd0, ok});
        chk({tag, "_ehdr"}, {31'd0, err_hdr_o}, {31'd0, eh});
        chk({tag, "_etrunc"}, {31'd0, err_trunc_o}, {31'd0, et});
        chk({tag, "_csum"}, {16'd0, csum_o}, {16'd0, cs});
    endtask

    task automatic quiet(input string tag);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_flags"}, {29'd0, ok_o, err_hdr_o, err_trunc_o}, 32'd0);
        chk({tag, "_csum"}, {16'd0, csum_o}, 32'd0);
    endtask

    initial begin
        reset_i  = 1'b1;
        data_i   = 8'h00;
        dataen_i = 1'b0;
        sop_i    = 1'b0;
        repeat (3) @(posedge CLK_i);
        #1;
        quiet("reset");
        chk("reset_len", {26'd0, hdr_len_o}, 32'd0);
        @(negedge CLK_i);
        reset_i = 1'b0;

        // T1 known-good header followed by payload
        load_t1();
        send(0, 19, 1'b1, 1'b0, dn);
        verdict("t1", 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("t1_len", {26'd0, hdr_len_o}, 32'd20);
        chk("t1_dones", dn, 1);
        send(0, 7, 1'b0, 1'b0, dn);
        chk("t1_payload_dones", dn, 0);
        quiet("t1_after");
        chk("t1_len_held", {26'd0, hdr_len_o}, 32'd20);

        // T2 corrupted byte 11
        load_t1();
        hdr[11] = 8'h62;
        send(0, 19, 1'b1, 1'b0, dn);
        verdict("t2", 1'b0, 1'b0, 1'b0, 16'hFFFE);
        chk("t2_dones", dn, 1);

        // T3 illegal IHL, then illegal version
        load_t1();
        hdr[0] = 8'h44;
        step(hdr[0], 1'b1, 1'b1);
        verdict("t3a", 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("t3a_len", {26'd0, hdr_len_o}, 32'd16);
        send(1, 19, 1'b0, 1'b0, dn);
        chk("t3a_dones", dn, 0);
        hdr[0] = 8'h65;
        step(hdr[0], 1'b1, 1'b1);
        verdict("t3b", 1'b0, 1'b1, 1'b0, 16'h0000);
        send(1, 19, 1'b0, 1'b0, dn);
        chk("t3b_dones", dn, 0);

        // T4 truncation at byte 10, then a full header
        load_t1();
        send(0, 9, 1'b1, 1'b0, dn);
        chk("t4_pre_dones", dn, 0);
        step(hdr[0], 1'b1, 1'b1);
        verdict("t4_trunc", 1'b0, 1'b0, 1'b1, 16'h0000);
        send(1, 19, 1'b0, 1'b0, dn);
        verdict("t4_ok", 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("t4_dones", dn, 1);

        // Truncation by an illegal byte 0: two back-to-back verdicts
        send(0, 5, 1'b1, 1'b0, dn);
        step(8'h44, 1'b1, 1'b1);
        verdict("t4b_trunc", 1'b0, 1'b0, 1'b1, 16'h0000);
        step(8'h00, 1'b0, 1'b0);
        verdict("t4b_ehdr", 1'b0, 1'b1, 1'b0, 16'h0000);
        step(8'h00, 1'b0, 1'b0);
        quiet("t4b_after");

        // T5 options with random gaps, then payload
        for (int i = 0; i < 24; i++) hdr[i] = t5[i];
        send(0, 23, 1'b1, 1'b1, dn);
        verdict("t5", 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("t5_len", {26'd0, hdr_len_o}, 32'd24);
        chk("t5_dones", dn, 1);
        send(0, 11, 1'b0, 1'b1, dn);
        chk("t5_payload_dones", dn, 0);

        // T6 reset at byte 7, remaining bytes without sop
        load_t1();
        send(0, 6, 1'b1, 1'b0, dn);
        @(negedge CLK_i);
        data_i   = hdr[7];
        dataen_i = 1'b1;
        reset_i  = 1'b1;
        #2;
        quiet("t6_rst");
        chk("t6_rst_len", {26'd0, hdr_len_o}, 32'd0);
        @(negedge CLK_i);
        reset_i = 1'b0;
        send(8, 19, 1'b0, 1'b0, dn);
        chk("t6_dones", dn, 0);
        quiet("t6_after");
        send(0, 19, 1'b1, 1'b0, dn);
        verdict("t6_ok", 1'b1, 1'b0, 1'b0, 16'h0000);

        step(8'h00, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
